// File: rtl/hadamard_fetch_ctrl.sv
// Read-side sequencer: drains N samples from the sample FIFO, packs them into one block and
// launches the Hadamard core. Optional WAIT watchdog is built when HADAMARD_CTRL_TIMEOUT_EN is defined.
module hadamard_fetch_ctrl #(
  parameter int DW      = 7,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic          fifo_valid,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_ren,
  input  logic          core_done,
  output logic          blk_start,
  output logic [N*DW-1:0] blk_data,
  output logic          busy,
  output logic [15:0]   blk_count,
  output logic          timeout_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW:0] N_L = (CW + 1)'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              ren_q;
  logic [CW:0]       in_flight;
  logic [N*DW-1:0]   collect;
  logic [N*DW-1:0]   collect_next;
  logic              load_blk;
  logic              expire;

  // FIFO handshake: a read is accepted on every cycle fifo_ren is high (only issued while
  // fifo_empty is low); its sample arrives with fifo_valid exactly one cycle later. ren_q
  // tracks that in-flight read so the total of landed plus pending samples never exceeds N.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    collect_next = collect;
    fifo_ren     = 1'b0;
    load_blk     = 1'b0;
    in_flight    = {1'b0, cnt} + {{CW{1'b0}}, ren_q};

    case (state)
      IDLE: begin
        if (enable) state_next = FILL;
      end
      FILL: begin
        fifo_ren = !fifo_empty && (in_flight < N_L);
        if (fifo_valid) begin
          for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) collect_next[k*DW +: DW] = fifo_dout;
          end
          cnt_next = cnt + 1'b1;
          if (cnt == CW'(N - 1)) state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // Completion wins over a same-cycle watchdog expiry.
        if (core_done || expire) state_next = enable ? FILL : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush) begin
      state_next   = IDLE;
      cnt_next     = '0;
      collect_next = '0;
      fifo_ren     = 1'b0;
    end

    // blk_data/blk_count update on entry to LAUNCH so they are stable alongside blk_start.
    load_blk = (state == FILL) && (state_next == LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      ren_q     <= 1'b0;
      collect   <= '0;
      blk_data  <= '0;
      blk_count <= '0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != IDLE);
      cnt     <= cnt_next;
      ren_q   <= fifo_ren;
      collect <= collect_next;
      if (load_blk) begin
        blk_data  <= collect_next;
        blk_count <= blk_count + 16'd1;
      end
    end
  end

  assign blk_start = (state == LAUNCH);

`ifdef HADAMARD_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  // wait_cnt sits at zero outside WAIT, so it is already cleared on every WAIT entry.
  assign expire = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1)) && !core_done && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (expire) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q | expire;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0 && (TIMEOUT > 0);
`endif

endmodule
